leve2_fetch: RTL and testbench
==============================

# leve2_fetch

Parametrised instruction-fetch front end for the second-generation LEVE core. It issues pipelined AXI read requests for sequential instruction addresses, keeping up to DEPTH requests outstanding, and buffers returned instructions in a prefetch FIFO. The FIFO feeds the decode stage through a valid/ready handshake. On a PC redirect from execute, the block clears the FIFO, discards all in-flight responses, and restarts fetching at the new PC with no bubble on the AR channel.

## Interface
- DEPTH, 4: prefetch FIFO entries and maximum outstanding reads; power of two, 2..16.
- RESET_PC, 0: first fetch address after reset; `XLEN bits.
- CLK  in  1  clock.
- RSTn  in  1  asynchronous, active-low reset.
- IPC_WE  in  1  redirect strobe from EX.
- INEXT_PC  in  `XLEN  redirect target; bits [1:0] must be 0.
- IF_VALID  out  1  FIFO head holds a valid instruction.
- IF_READY  in  1  decode accepts the head.
- IF_PC  out  `XLEN  PC of the head.
- IF_INSTR  out  32  instruction word of the head.
- IF_ERR  out  1  head carries a bus error (present only with the macro; see Configuration).
- RII  AXIR.init  read initiator; uses ARVALID, ARREADY, ARADDR (`XLEN), RVALID, RREADY, RDATA (32), RRESP (2). Single-beat reads, in-order responses.

## Operation
- Reset values:
  - outputs: IF_VALID=0, ARVALID=0, RREADY=0; IF_PC, IF_INSTR, IF_ERR and ARADDR are 0.
  - internal state: fetch PC=RESET_PC, outstanding=0, drop=0, FIFO empty.
- Credit rule: issue an AR only when occupancy + outstanding < DEPTH.
  - occupancy is the number of FIFO entries.
  - outstanding counts issued-but-unreturned reads, including those marked for drop.
  - The FIFO therefore never overflows, and RREADY=1 whenever out of reset.
- AR channel:
  - ARADDR = fetch PC. On an AR handshake, fetch PC += 4 and outstanding += 1.
  - While ARVALID=1 and ARREADY=0, ARVALID and ARADDR are held stable, including across a redirect.
- R channel: an R handshake decrements outstanding.
  - If drop > 0, the beat is discarded and drop -= 1.
  - Otherwise the entry {pc, RDATA, err} is pushed. The pc comes from a return-PC register that advances by 4 per kept beat.
- Redirect (IPC_WE=1 in cycle N):
  - FIFO cleared.
  - drop = outstanding after cycle N's updates, including an AR handshaking and excluding an R beat returning in cycle N.
  - An R beat in cycle N is discarded, and does not reduce the new drop count.
  - fetch PC and return PC are set to INEXT_PC.
  - If an AR was pending without handshake in cycle N, it completes at its old address, counts toward drop, and the new AR follows it.
- Simultaneous events:
  - An IF handshake together with IPC_WE: redirect wins and the pop is irrelevant.
  - A push and a pop in the same cycle keep occupancy unchanged.
  - Back-to-back redirects accumulate correctly through outstanding.
- Counter wrap:
  - outstanding and drop are $clog2(DEPTH)+1 bits and never exceed DEPTH.
  - The fetch PC wraps modulo 2^`XLEN.

## Timing
- After RSTn deasserts, ARVALID=1 with ARADDR=RESET_PC in the first clock edge's following cycle.
- An R beat accepted in cycle N appears as IF_VALID=1 in cycle N+1 (registered FIFO, no bypass).
- An AR is issued in the same cycle that credit becomes available (combinational credit check on registered counters).
- Redirect in cycle N:
  - IF_VALID=0 in N+1.
  - ARADDR=INEXT_PC with ARVALID=1 in N+1, if the AR channel was idle or handshook in N.
- Sustained throughput is 1 instruction/cycle when ARREADY=RVALID=IF_READY=1 and memory latency < DEPTH cycles.

## Configuration
- LEVE_FETCH_ERR_EN:
  - Defined: IF_ERR exists; err = (RRESP != OKAY) is stored per entry.
  - Defined: after an erroring beat is pushed, AR issue stops until the next redirect. Remaining outstanding beats are still pushed.
  - Undefined: RRESP is ignored, there is no IF_ERR port, the FIFO entry has no err bit, and fetch never stalls on errors.

## Structure
- leve_pkg holds:
  - typedef fetch_entry_t {pc, instr, err}, with err under the macro;
  - AXI RRESP constants OKAY/SLVERR/DECERR.
- One sub-module, leve_sync_fifo: parametrised width/depth with push, pop, synchronous clear, count, and registered outputs.
- Counters, credit logic and the drop logic live in leve2_fetch.

## Test plan
- Reset, then ARREADY=RVALID=IF_READY=1 with memory latency 2 and DEPTH=4: ARADDR sequence 0,4,8,C,…; IF_PC 0,4,8,… one per cycle after fill.
- IF_READY=0 with DEPTH=4: exactly 4 ARs issue, then ARVALID=0; no R beat lost. Setting IF_READY=1 resumes fetch at 0x10.
- Redirect to 0x100 with 3 reads outstanding: the next 3 R beats are discarded; first IF_PC after the redirect is 0x100 and never 0x0C.
- Redirect while ARVALID=1, ARREADY=0 at 0x8: ARADDR is held at 0x8 until handshake, then 0x200; the 0x8 data is dropped.
- Redirect coincident with an R beat and an IF handshake: the beat is dropped, the FIFO is empty next cycle, and the next IF_PC equals INEXT_PC.
- With LEVE_FETCH_ERR_EN, RRESP=SLVERR at 0x8: the entry has IF_ERR=1 with IF_PC=0x8, ARVALID stays 0 until IPC_WE, then fetch resumes.

Source files
------------

// File: rtl/leve_pkg.sv
// rtl/leve_pkg.sv - shared fetch-entry type and AXI response codes for the LEVE fetch path
// LEVE_FETCH_ERR_EN adds a per-entry bus-error flag to fetch_entry_t.
`ifndef XLEN
`define XLEN 32
`endif

package leve_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef struct packed {
    logic [`XLEN-1:0] pc;
    logic [31:0]      instr;
`ifdef LEVE_FETCH_ERR_EN
    logic             err;
`endif
  } fetch_entry_t;

endpackage

// File: rtl/leve_sync_fifo.sv
// rtl/leve_sync_fifo.sv - synchronous FIFO with clear, occupancy count and registered head outputs
module leve_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr, rd_ptr_nxt;
  logic             push_en, pop_en;
  logic [CW-1:0]    after_pop, count_nxt;

  always_comb begin
    pop_en     = pop && (count != '0);
    push_en    = push && ((count != CW'(DEPTH)) || pop_en);
    after_pop  = count - CW'(pop_en);
    count_nxt  = after_pop + CW'(push_en);
    rd_ptr_nxt = rd_ptr + AW'(pop_en);
  end

  // Head register is loaded with the next head so that dout/valid come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      dout   <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      count  <= count_nxt;
      valid  <= (count_nxt != '0);
      if (after_pop == '0) dout <= din;
      else                 dout <= mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push_en && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/leve2_fetch.sv
// rtl/leve2_fetch.sv - LEVE2 instruction fetch: credit-limited AXI reads into a prefetch FIFO
// LEVE_FETCH_ERR_EN: IF_ERR port, per-entry error flag and AR stall after an erroring beat.
`ifndef XLEN
`define XLEN 32
`endif

module leve2_fetch
  import leve_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter logic [`XLEN-1:0] RESET_PC = '0
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             IPC_WE,
  input  logic [`XLEN-1:0] INEXT_PC,
  output logic             IF_VALID,
  input  logic             IF_READY,
  output logic [`XLEN-1:0] IF_PC,
  output logic [31:0]      IF_INSTR,
`ifdef LEVE_FETCH_ERR_EN
  output logic             IF_ERR,
`endif
  output logic             ARVALID,
  input  logic             ARREADY,
  output logic [`XLEN-1:0] ARADDR,
  input  logic             RVALID,
  output logic             RREADY,
  input  logic [31:0]      RDATA,
  input  logic [1:0]       RRESP
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = $bits(fetch_entry_t);

  logic [`XLEN-1:0] fetch_pc, ret_pc, pc_base;
  logic [CW-1:0]    outstanding, drop, occ;
  logic [CW-1:0]    out_nxt, occ_nxt, drop_nxt;
  logic [CW:0]      credit_sum;
  logic             ar_hs, ar_pend, r_hs, if_hs, keep, issue, stall_nxt;
  fetch_entry_t     push_entry, head;

  assign ar_hs   = ARVALID && ARREADY;
  assign ar_pend = ARVALID && !ARREADY;
  assign r_hs    = RVALID && RREADY;
  assign if_hs   = IF_VALID && IF_READY;
  assign keep    = r_hs && (drop == '0) && !IPC_WE;
  assign out_nxt = outstanding + CW'(ar_hs) - CW'(r_hs);
  assign occ_nxt = IPC_WE ? '0 : (occ + CW'(keep) - CW'(if_hs));
  // A redirect must also discard the beat of an AR still waiting for ARREADY.
  assign drop_nxt   = IPC_WE ? (out_nxt + CW'(ar_pend)) : (drop - CW'(r_hs && (drop != '0)));
  assign pc_base    = IPC_WE ? INEXT_PC : fetch_pc;
  assign credit_sum = {1'b0, occ_nxt} + {1'b0, out_nxt};
  assign issue      = !ar_pend && (credit_sum < (CW+1)'(DEPTH)) && !stall_nxt;

`ifdef LEVE_FETCH_ERR_EN
  logic stall;
  assign stall_nxt = IPC_WE ? 1'b0 : (stall || (keep && (RRESP != OKAY)));
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) stall <= 1'b0;
    else       stall <= stall_nxt;
  end
  assign IF_ERR = head.err;
`else
  logic unused_rresp;
  assign unused_rresp = ^RRESP;
  assign stall_nxt    = 1'b0;
`endif

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = ret_pc;
    push_entry.instr = RDATA;
`ifdef LEVE_FETCH_ERR_EN
    push_entry.err   = (RRESP != OKAY);
`endif
  end

  // fetch_pc is the address the next newly-issued AR will carry.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      fetch_pc    <= RESET_PC;
      ret_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      ARVALID     <= 1'b0;
      ARADDR      <= '0;
      RREADY      <= 1'b0;
    end else begin
      outstanding <= out_nxt;
      drop        <= drop_nxt;
      RREADY      <= 1'b1;
      ret_pc      <= IPC_WE ? INEXT_PC : (keep ? ret_pc + `XLEN'(4) : ret_pc);
      if (ar_pend) begin
        fetch_pc <= pc_base;
      end else if (issue) begin
        ARVALID  <= 1'b1;
        ARADDR   <= pc_base;
        fetch_pc <= pc_base + `XLEN'(4);
      end else begin
        ARVALID  <= 1'b0;
        fetch_pc <= pc_base;
      end
    end
  end

  leve_sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (RSTn),
    .push  (keep),
    .pop   (if_hs),
    .clear (IPC_WE),
    .din   (push_entry),
    .dout  (head),
    .valid (IF_VALID),
    .count (occ)
  );

  assign IF_PC    = head.pc;
  assign IF_INSTR = head.instr;

endmodule

// File: tb/tb_leve2_fetch.sv
// tb/tb_leve2_fetch.sv - scoreboard bench for leve2_fetch with a latency-2 AXI read memory model
// Build with LEVE_FETCH_ERR_EN to exercise the error-stall path.
`timescale 1ns/1ps
module tb_leve2_fetch;
  import leve_pkg::*;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ipc_we = 1'b0;
  logic [31:0] inext_pc = '0;
  logic        if_ready = 1'b0;
  logic        arready = 1'b1;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        if_valid, arvalid, rready;
  logic [31:0] if_pc, if_instr, araddr;
`ifdef LEVE_FETCH_ERR_EN
  logic        if_err;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ar_cnt = 0, r_cnt = 0, if_cnt = 0, base = 0;
  logic        rvalid_en = 1'b1;
  logic [31:0] err_addr = '1;
  logic [31:0] exp_next = '0;
  logic [31:0] exp_pc, first_pc = '0, held = '0;
  logic        after_redir = 1'b0;
  req_t        mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] ar_log[$];

  always #5 clk = ~clk;

  leve2_fetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .CLK      (clk),
    .RSTn     (rst_n),
    .IPC_WE   (ipc_we),
    .INEXT_PC (inext_pc),
    .IF_VALID (if_valid),
    .IF_READY (if_ready),
    .IF_PC    (if_pc),
    .IF_INSTR (if_instr),
`ifdef LEVE_FETCH_ERR_EN
    .IF_ERR   (if_err),
`endif
    .ARVALID  (arvalid),
    .ARREADY  (arready),
    .ARADDR   (araddr),
    .RVALID   (rvalid),
    .RREADY   (rready),
    .RDATA    (rdata),
    .RRESP    (rresp)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic extend();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 32'd4;
    end
  endtask

  task automatic fill(input logic [31:0] start);
    exp_q.delete();
    exp_next = start;
    extend();
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Memory model and scoreboard: inputs settle at negedge, handshakes are evaluated 1ns later.
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      mem_q.delete();
      rvalid = 1'b0;
      rdata  = '0;
      rresp  = OKAY;
      cyc    = 0;
      fill(32'h0);
    end else begin
      cyc++;
      if (rvalid_en && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        rvalid = 1'b1;
        rdata  = mem_f(mem_q[0].addr);
        rresp  = (mem_q[0].addr == err_addr) ? SLVERR : OKAY;
      end else begin
        rvalid = 1'b0;
        rdata  = '0;
        rresp  = OKAY;
      end
      if (rvalid && rready) begin
        void'(mem_q.pop_front());
        r_cnt++;
      end
      if (arvalid && arready) begin
        mem_q.push_back(req_t'{araddr, cyc + 2});
        ar_log.push_back(araddr);
        ar_cnt++;
      end
      if (ipc_we) begin
        fill(inext_pc);
        after_redir = 1'b1;
      end else if (if_valid && if_ready) begin
        exp_pc = exp_q.pop_front();
        chk("if_pc", if_pc, exp_pc);
        chk("if_instr", if_instr, mem_f(exp_pc));
`ifdef LEVE_FETCH_ERR_EN
        chk("if_err", if_err, exp_pc == err_addr);
`endif
        if (after_redir) begin
          first_pc    = if_pc;
          after_redir = 1'b0;
        end
        if_cnt++;
        if (exp_q.size() < 8) extend();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    step(3);
    #2;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_instr", if_instr, 0);
    step(1);
    rst_n = 1'b1;
    step(1);
    #2;
    chk("first_arvalid", arvalid, 1);
    chk("first_araddr", araddr, 0);
    chk("first_rready", rready, 1);

    // Decode stalled from reset: credit limits issue to DEPTH reads.
    step(14);
    #2;
    chk("stall_ar_cnt", ar_cnt, 4);
    chk("stall_r_cnt", r_cnt, 4);
    chk("stall_arvalid", arvalid, 0);
    chk("stall_if_valid", if_valid, 1);
    chk("stall_head_pc", if_pc, 0);
    step(1);
    if_ready = 1'b1;
    step(6);
    #2;
    chk("resume_addr", (ar_log.size() > 4) ? ar_log[4] : 32'hDEAD_BEEF, 32'h10);

    step(8);
    #2;
    base = if_cnt;
    step(16);
    #2;
    chk("throughput", if_cnt - base, 16);
    for (int i = 0; i < 8; i++)
      chk("araddr_seq", (ar_log.size() > i) ? ar_log[i] : 32'hDEAD_BEEF, 32'(4 * i));

    // Redirect with three reads outstanding and one entry buffered.
    step(1);
    if_ready = 1'b0;
    step(12);
    rvalid_en = 1'b0;
    if_ready  = 1'b1;
    step(3);
    if_ready = 1'b0;
    step(8);
    #2;
    chk("pre_redir_outstanding", mem_q.size(), 3);
    chk("pre_redir_arvalid", arvalid, 0);
    step(1);
    ipc_we   = 1'b1;
    inext_pc = 32'h100;
    step(1);
    ipc_we    = 1'b0;
    rvalid_en = 1'b1;
    if_ready  = 1'b1;
    #2;
    chk("redir_if_valid", if_valid, 0);
    chk("redir_arvalid", arvalid, 1);
    chk("redir_araddr", araddr, 32'h100);
    base = if_cnt;
    step(20);
    #2;
    chk("redir_progress", (if_cnt - base) >= 10, 1);
    chk("redir_first_pc", first_pc, 32'h100);

    // Redirect while an AR is waiting for ARREADY.
    step(1);
    arready = 1'b0;
    step(1);
    #2;
    held = araddr;
    chk("hold_arvalid", arvalid, 1);
    step(1);
    ipc_we   = 1'b1;
    inext_pc = 32'h200;
    step(1);
    ipc_we = 1'b0;
    #2;
    chk("hold_araddr", araddr, held);
    chk("hold_arvalid_kept", arvalid, 1);
    step(1);
    arready = 1'b1;
    step(1);
    #2;
    chk("post_hold_arvalid", arvalid, 1);
    chk("post_hold_araddr", araddr, 32'h200);
    step(12);
    #2;
    chk("hold_first_pc", first_pc, 32'h200);

    // Redirect coincident with an R beat and an IF handshake.
    step(1);
    ipc_we   = 1'b1;
    inext_pc = 32'h300;
    #2;
    chk("coinc_pre", rvalid && rready && if_valid && if_ready, 1);
    step(1);
    ipc_we = 1'b0;
    #2;
    chk("coinc_if_valid", if_valid, 0);
    chk("coinc_araddr", araddr, 32'h300);
    step(12);
    #2;
    chk("coinc_first_pc", first_pc, 32'h300);

`ifdef LEVE_FETCH_ERR_EN
    step(1);
    err_addr = 32'h408;
    ipc_we   = 1'b1;
    inext_pc = 32'h400;
    step(1);
    ipc_we = 1'b0;
    step(16);
    #2;
    chk("err_stall_arvalid", arvalid, 0);
    chk("err_drained", if_valid, 0);
    chk("err_first_pc", first_pc, 32'h400);
    step(1);
    err_addr = '1;
    ipc_we   = 1'b1;
    inext_pc = 32'h500;
    step(1);
    ipc_we = 1'b0;
    #2;
    chk("err_resume_arvalid", arvalid, 1);
    chk("err_resume_araddr", araddr, 32'h500);
    step(12);
    #2;
    chk("err_resume_first_pc", first_pc, 32'h500);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
